// File: rtl/pe_ipad_window.sv
// rtl/pe_ipad_window.sv - circular input scratchpad with sliding-window replay for the PE fetch stage
module pe_ipad_window #(
    parameter int DWD     = 16,
    parameter int DEPTH   = 32,
    parameter int CONF_WD = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [CONF_WD-1:0] i_conf_len,
    input  logic [CONF_WD-1:0] i_conf_stride,
    input  logic [CONF_WD-1:0] i_conf_nwin,
    input  logic [CONF_WD-1:0] i_conf_rep,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic               i_wvalid,
    output logic               o_wready,
    input  logic [DWD-1:0]     i_wdata,
    output logic               o_rvalid,
    input  logic               i_rready,
    output logic [DWD-1:0]     o_rdata,
    output logic               o_rzero,
    output logic               o_rlast,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = 2 * CONF_WD + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [31:0]   DEPTH_32 = DEPTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [DWD-1:0]     r_mem [DEPTH];
    logic [DEPTH-1:0]   r_zflag;
    logic [AW-1:0]      r_waddr;
    logic [AW-1:0]      r_base;
    logic [CW-1:0]      r_count;
    logic [TW-1:0]      r_wcnt;
    logic [TW-1:0]      r_total;
    logic [CONF_WD-1:0] r_len;
    logic [CONF_WD-1:0] r_stride;
    logic [CONF_WD-1:0] r_nwin;
    logic [CONF_WD-1:0] r_rep;
    logic [CONF_WD-1:0] r_idx;
    logic [CONF_WD-1:0] r_rcnt;
    logic [CONF_WD-1:0] r_win;
    logic               r_rvalid;
    logic [DWD-1:0]     r_rdata;
    logic               r_rzero;
    logic               r_rlast;
    logic               r_done;
    logic               r_err;

    logic               w_cfg_bad;
    logic [TW-1:0]      w_total;
    logic               w_wready;
    logic               w_wr_hs;
    logic               w_avail;
    logic               w_issue;
    logic               w_end_pass;
    logic               w_last_rep;
    logic               w_last_win;
    logic               w_slide;
    logic               w_job_end;
    logic               w_drained;
    logic [CW-1:0]      w_freed;
    logic [AW-1:0]      w_raddr;
    logic               w_accept;

    assign w_cfg_bad = (i_conf_len == '0) || (32'(i_conf_len) > DEPTH_32) ||
                       (i_conf_stride == '0) || (i_conf_stride > i_conf_len) ||
                       (i_conf_nwin == '0) || (i_conf_rep == '0);
    assign w_total   = TW'(i_conf_len) + (TW'(i_conf_nwin) - TW'(1)) * TW'(i_conf_stride);
    assign w_accept  = (r_state == S_IDLE) && i_start && !i_abort && !w_cfg_bad;

    // Writes stop when the ring is full or the job's pixel budget is used up.
    assign w_wready  = (r_state == S_RUN) && (r_count < DEPTH_C) && (r_wcnt < r_total);
    assign w_wr_hs   = w_wready && i_wvalid;

    // An entry of the current window may be read once it has actually been written.
    assign w_avail    = 32'(r_idx) < 32'(r_count);
    assign w_issue    = (r_state == S_RUN) && (!r_rvalid || i_rready) && w_avail;
    assign w_end_pass = (r_idx == r_len - CONF_WD'(1));
    assign w_last_rep = (r_rcnt == r_rep - CONF_WD'(1));
    assign w_last_win = (r_win == r_nwin - CONF_WD'(1));
    assign w_slide    = w_issue && w_end_pass && w_last_rep;
    assign w_job_end  = w_slide && w_last_win;
    assign w_drained  = !r_rvalid || i_rready;
    assign w_raddr    = r_base + AW'(r_idx);

    // The final window releases everything it held; earlier ones only release the stride.
    assign w_freed = !w_slide  ? '0 :
                     w_last_win ? CW'(r_len) : CW'(r_stride);

    assign o_wready = w_wready;
    assign o_rvalid = r_rvalid;
    assign o_rdata  = r_rdata;
    assign o_rzero  = r_rzero;
    assign o_rlast  = r_rlast;
    assign o_busy   = (r_state != S_IDLE);
    assign o_done   = r_done;
    assign o_err    = r_err;

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; abort overrides everything including a same-cycle start.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_RUN;
            S_RUN:   if (w_job_end) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_drained) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (i_abort) begin
            w_state_nxt = S_IDLE;
        end
    end

    // Pixel storage; contents need no reset because reads are gated by the fill count.
    always_ff @(posedge i_clk) begin
        if (w_wr_hs) begin
            r_mem[r_waddr] <= i_wdata;
        end
    end

    // Configuration latch, pointers, counters, zero flags and the output register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_zflag  <= '0;
            r_waddr  <= '0;
            r_base   <= '0;
            r_count  <= '0;
            r_wcnt   <= '0;
            r_total  <= '0;
            r_len    <= '0;
            r_stride <= '0;
            r_nwin   <= '0;
            r_rep    <= '0;
            r_idx    <= '0;
            r_rcnt   <= '0;
            r_win    <= '0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rzero  <= 1'b0;
            r_rlast  <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else if (i_abort) begin
            r_waddr  <= '0;
            r_base   <= '0;
            r_count  <= '0;
            r_wcnt   <= '0;
            r_idx    <= '0;
            r_rcnt   <= '0;
            r_win    <= '0;
            r_rvalid <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= (r_state == S_DRAIN) && w_drained;

            if ((r_state == S_IDLE) && i_start) begin
                r_err <= w_cfg_bad;
                if (!w_cfg_bad) begin
                    r_len    <= i_conf_len;
                    r_stride <= i_conf_stride;
                    r_nwin   <= i_conf_nwin;
                    r_rep    <= i_conf_rep;
                    r_total  <= w_total;
                    r_waddr  <= '0;
                    r_base   <= '0;
                    r_count  <= '0;
                    r_wcnt   <= '0;
                    r_idx    <= '0;
                    r_rcnt   <= '0;
                    r_win    <= '0;
                end
            end else begin
                if (w_wr_hs) begin
                    r_zflag[r_waddr] <= (i_wdata == '0);
                    r_waddr          <= r_waddr + AW'(1);
                    r_wcnt           <= r_wcnt + TW'(1);
                end
                r_count <= r_count + CW'(w_wr_hs) - w_freed;

                if (w_issue) begin
                    r_rvalid <= 1'b1;
                    r_rdata  <= r_mem[w_raddr];
                    r_rzero  <= r_zflag[w_raddr];
                    r_rlast  <= w_slide;
                    if (w_end_pass) begin
                        r_idx <= '0;
                        if (w_last_rep) begin
                            r_rcnt <= '0;
                            r_win  <= r_win + CONF_WD'(1);
                            r_base <= r_base + AW'(r_stride);
                        end else begin
                            r_rcnt <= r_rcnt + CONF_WD'(1);
                        end
                    end else begin
                        r_idx <= r_idx + CONF_WD'(1);
                    end
                end else if (i_rready) begin
                    r_rvalid <= 1'b0;
                end
            end
        end
    end

endmodule
